// File: rtl/regfile_arb_pkg.sv
// Shared types and width helpers for the register-file port arbiters.
package regfile_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to index n distinct values (never less than one).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational round-robin search: first set bit of valid at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int unsigned cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && (j == cand) && valid[j]) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port with bounded lock bursts
// and a registered write stage.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned MAX_BURST = 4,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_lock,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [idx_w(NREQ)-1:0]     grant_id,
    output logic                       locked
);

    localparam int unsigned ID_W = idx_w(NREQ);
    localparam int unsigned BC_W = idx_w(MAX_BURST + 1);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [BC_W-1:0]   burst_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              xfer;
    logic [ID_W-1:0]   xfer_idx;
    logic [ID_W-1:0]   ptr_next;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_priority_picker #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!reset) begin
                if (state == ARB_LOCKED) begin
                    req_ready[i] = (owner == ID_W'(i)) && req_valid[i];
                end else begin
                    req_ready[i] = pick_found && (pick_idx == ID_W'(i));
                end
            end
        end
    end

    // In a tenure the owner is the only candidate, so it doubles as the release index.
    always_comb begin
        xfer     = |(req_valid & req_ready);
        xfer_idx = (state == ARB_LOCKED) ? owner : pick_idx;
        ptr_next = (xfer_idx == ID_W'(NREQ - 1)) ? '0 : xfer_idx + ID_W'(1);
        sel_lock = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (xfer_idx == ID_W'(i)) begin
                sel_lock = req_lock[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_id  <= '0;
        end else begin
            rf_we <= xfer && !(ZERO_REG && (sel_addr == '0));
            if (xfer) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= xfer_idx;
            end
            case (state)
                ARB_IDLE: begin
                    if (xfer) begin
                        if (sel_lock && (MAX_BURST > 1)) begin
                            state     <= ARB_LOCKED;
                            owner     <= xfer_idx;
                            burst_cnt <= BC_W'(1);
                        end else begin
                            rr_ptr <= ptr_next;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && sel_lock && (burst_cnt != BC_W'(MAX_BURST - 1))) begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                    end else begin
                        state     <= ARB_IDLE;
                        burst_cnt <= '0;
                        rr_ptr    <= ptr_next;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign locked = (state == ARB_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter (NREQ=4, MAX_BURST=4, ZERO_REG=1).
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_valid;
    logic [3:0]        req_lock;
    logic [19:0]       req_addr;
    logic [127:0]      req_data;
    logic [3:0]        req_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic [1:0]        grant_id;
    logic              locked;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_gid;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic       exp_locked;
    } vec_t;

    vec_t tbl[19];

    regfile_write_arbiter #(
        .NREQ      (4),
        .DATA_W    (32),
        .ADDR_W    (5),
        .MAX_BURST (4),
        .ZERO_REG  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] addr_of(input int i);
        return 5'(4 * i + 3);
    endfunction

    function automatic logic [31:0] data_of(input int i, input int s);
        return 32'hC0DE_0000 | 32'(i << 8) | 32'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input int s);
        req_valid = v;
        req_lock  = l;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*5 +: 5]   = addr_of(i);
            req_data[i*32 +: 32] = data_of(i, s);
        end
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic lk);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(exp_gid));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(exp_addr));
        chk({tag, ".rf_wdata"}, rf_wdata, exp_data);
    endtask

    initial begin
        // Pointer trace (starting 0): 2 ->3, rotate x6, idle, lock burst on 1, owner-3 drop, clean unlock.
        tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1};
        tbl[9]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1};
        tbl[10] = '{4'b0110, 4'b0010, 4'b0010, 1'b1};
        tbl[11] = '{4'b0110, 4'b0010, 4'b0010, 1'b0};
        tbl[12] = '{4'b0110, 4'b0010, 4'b0100, 1'b0};
        tbl[13] = '{4'b1001, 4'b1000, 4'b1000, 1'b1};
        tbl[14] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[16] = '{4'b0011, 4'b0010, 4'b0010, 1'b1};
        tbl[17] = '{4'b0011, 4'b0000, 4'b0010, 1'b0};
        tbl[18] = '{4'b0011, 4'b0000, 4'b0001, 1'b0};

        reset = 1'b1;
        drive(4'b1111, 4'b0000, 0);
        exp_addr = '0;
        exp_data = '0;
        exp_gid  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.ready", 32'(req_ready), 32'(4'b0000));
        check_outputs("reset", 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 0);
        reset = 1'b0;

        for (int s = 0; s < 19; s++) begin
            @(negedge clk);
            drive(tbl[s].valid, tbl[s].lock, s);
            #1;
            chk($sformatf("v%0d.ready", s), 32'(req_ready), 32'(tbl[s].exp_ready));
            if (tbl[s].exp_ready != 4'b0000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (tbl[s].exp_ready[i]) exp_gid = 2'(i);
                end
                exp_addr = addr_of(int'(exp_gid));
                exp_data = data_of(int'(exp_gid), s);
            end
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", s), tbl[s].exp_ready != 4'b0000, tbl[s].exp_locked);
        end

        // Address 0 completes the handshake but is suppressed at the write port (rr_ptr=1).
        @(negedge clk);
        drive(4'b0010, 4'b0000, 40);
        req_addr[5 +: 5] = 5'd0;
        #1;
        chk("zero.ready", 32'(req_ready), 32'(4'b0010));
        exp_gid  = 2'd1;
        exp_addr = 5'd0;
        exp_data = data_of(1, 40);
        @(posedge clk);
        #1;
        check_outputs("zero", 1'b0, 1'b0);

        // Single requester 2 with a known payload (rr_ptr=2).
        @(negedge clk);
        drive(4'b0100, 4'b0000, 41);
        req_addr[10 +: 5]  = 5'd7;
        req_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("single.ready", 32'(req_ready), 32'(4'b0100));
        exp_gid  = 2'd2;
        exp_addr = 5'd7;
        exp_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check_outputs("single", 1'b1, 1'b0);

        // Lock tenure by requester 1 (rr_ptr=3), then reset lands on the next locked transfer.
        @(negedge clk);
        drive(4'b0010, 4'b0010, 42);
        #1;
        chk("rstlock.ready", 32'(req_ready), 32'(4'b0010));
        exp_gid  = 2'd1;
        exp_addr = addr_of(1);
        exp_data = data_of(1, 42);
        @(posedge clk);
        #1;
        check_outputs("rstlock", 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid.ready", 32'(req_ready), 32'(4'b0000));
        exp_gid  = '0;
        exp_addr = '0;
        exp_data = '0;
        @(posedge clk);
        #1;
        check_outputs("rstmid", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 43);
        #1;
        chk("postrst.ready", 32'(req_ready), 32'(4'b0001));
        exp_gid  = 2'd0;
        exp_addr = addr_of(0);
        exp_data = data_of(0, 43);
        @(posedge clk);
        #1;
        check_outputs("postrst", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32-entry register file among NREQ requesters, such as the ALU writeback, the load unit and the CSR path. Each requester uses a valid/ready handshake, and the block grants access round-robin. A requester can lock the port for a bounded burst of back-to-back writes. The accepted write is registered and driven onto the register file's write port one cycle later.

## Interface
Parameters:
- NREQ, default 4: number of requesters; must be at least 2.
- DATA_W, default 32: write data width.
- ADDR_W, default 5: register address width.
- MAX_BURST, default 4: maximum number of transfers per lock tenure; must be at least 1.
- ZERO_REG, default 1: when 1, writes to address 0 are accepted but never reach the register file.

Ports:
- clk  in  1  clock; every state change happens on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  requester i has a write pending.
- req_lock  in  NREQ  requester i asks to keep the port after this transfer.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  packed data; requester i occupies slice [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  combinational one-hot-or-zero grant.
- rf_we  out  1  register file write enable, registered.
- rf_waddr  out  ADDR_W  register file write address, registered.
- rf_wdata  out  DATA_W  register file write data, registered.
- grant_id  out  clog2(NREQ)  index of the last accepted requester, registered.
- locked  out  1  high while the arbiter is in the ARB_LOCKED state.

## Operation
- Transfer: requester i transfers in a cycle when req_valid[i] and req_ready[i] are both high. At most one transfer happens per cycle.
- State machine:
  - ARB_IDLE: req_ready goes to the first valid requester, searching from rr_ptr upward and wrapping modulo NREQ. If no requester is valid, req_ready is 0.
  - ARB_IDLE to ARB_LOCKED: a transfer with req_lock[i]=1 and MAX_BURST>1 moves to ARB_LOCKED, with owner=i and burst_cnt=1.
  - ARB_LOCKED: only the owner may receive req_ready, which equals req_valid[owner]. All other requesters see ready=0.
  - ARB_LOCKED to ARB_IDLE: leave on any of these three events:
    - the owner transfers with req_lock=0;
    - the owner's transfer brings burst_cnt to MAX_BURST (forced release; that transfer is still accepted);
    - the owner holds req_valid=0 for one cycle, with no transfer.
- Round-robin pointer:
  - It changes only on release or on an unlocked transfer from ARB_IDLE.
  - Its new value is (granted index + 1) mod NREQ.
  - It wraps from NREQ-1 to 0.
  - It is not advanced by transfers made inside a lock tenure.
- Write path:
  - The cycle after a transfer, rf_we=1, and rf_waddr and rf_wdata carry the transferred values.
  - When ZERO_REG=1 and addr=0, the transfer still completes (ready is high), but rf_we=0 that cycle. rf_waddr, rf_wdata and grant_id still update.
  - With no transfer, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Width: burst_cnt is clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.

## Timing
- Reset values: state=ARB_IDLE, rr_ptr=0, burst_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, locked=0. req_ready is 0 while reset is high.
- Latency: exactly one cycle from the transfer edge to rf_we. The sustained rate is one write per cycle.
- Combinational paths: req_ready depends combinationally on req_valid, state and rr_ptr only. It never depends on req_addr or req_data.
- Simultaneous events:
  - When all requesters are valid, rr_ptr selects exactly one.
  - A forced release and the owner's lock request in the same cycle resolve as a release.
  - The owner may be re-granted in ARB_IDLE the next cycle only if it wins round-robin from the advanced pointer.
- Reset mid-burst: the lock tenure is abandoned. No rf_we appears in the cycle after reset is asserted, even if a transfer was in flight.
- Requester obligations: a requester keeps req_valid, req_addr and req_data stable until it transfers. The arbiter does not check this.

## Structure
- Shared package regfile_arb_pkg contains:
  - the typedef enum arb_state_t {ARB_IDLE, ARB_LOCKED};
  - the localparam-derived width helper for grant_id and burst_cnt.
- Sub-module rr_priority_picker: a combinational NREQ-wide round-robin search from rr_ptr. It outputs found and idx, and is reused by the future read-port arbiter.
- Top level: contains the state register, rr_ptr, burst_cnt and the output register stage.

## Test plan
- Single requester, NREQ=4: req 2 valid with addr=7 and data=0xDEADBEEF. Required: ready[2]=1 that cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, grant_id=2.
- All four requesters valid continuously with lock=0. Required: grant order 0,1,2,3,0,1 on consecutive cycles, with rf_we=1 every cycle.
- Requester 1 holds lock=1 for 6 transfers with MAX_BURST=4. Required: 4 consecutive grants to 1, locked=1 during the tenure, then a forced release; requester 2 (valid) is granted next.
- Owner 3 drops valid for one cycle while locked. Required: the lock releases, and requester 0 (waiting) is granted the following cycle.
- Write to addr 0 with ZERO_REG=1. Required: ready=1 and the transfer completes, but rf_we=0 in the next cycle.
- Reset asserted in the same cycle as a locked transfer. Required: no rf_we the next cycle; state returns to ARB_IDLE with rr_ptr=0, so requester 0 is granted first.
